// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle RISC-V control FSM and its ALU decoder.
package multicycle_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecuteR,
        StExecuteI,
        StAluWb,
        StBeq,
        StJal
    } state_e;

    // Opcodes (instr[6:0])
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpRtype = 7'b0110011;
    localparam logic [6:0] OpItype = 7'b0010011;
    localparam logic [6:0] OpBeq   = 7'b1100011;
    localparam logic [6:0] OpJal   = 7'b1101111;

    // FSM request to the ALU decoder
    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    // ALU operation
    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluSlt = 3'b101;

    // ALU operand selects
    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARegA  = 2'b10;
    localparam logic [1:0] SrcBRegB  = 2'b00;
    localparam logic [1:0] SrcBImm   = 2'b01;
    localparam logic [1:0] SrcBFour  = 2'b10;

    // Result bus select
    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResMemData   = 2'b01;
    localparam logic [1:0] ResAluResult = 2'b10;

    // Immediate format
    localparam logic [1:0] ImmI = 2'b00;
    localparam logic [1:0] ImmS = 2'b01;
    localparam logic [1:0] ImmB = 2'b10;
    localparam logic [1:0] ImmJ = 2'b11;

    // Immediate format depends only on the opcode, independent of FSM state
    function automatic logic [1:0] imm_src_for(logic [6:0] op);
        logic [1:0] imm;
        unique case (op)
            OpStore: imm = ImmS;
            OpBeq:   imm = ImmB;
            OpJal:   imm = ImmJ;
            default: imm = ImmI;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU decoder: maps FSM alu_op plus funct fields to an ALU operation.
module alu_decoder
    import multicycle_pkg::*;
(
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic [1:0] alu_op_i,
    output logic [2:0] alu_control_o,
    output logic       funct_illegal_o
);

    // Select ALU operation; unsupported funct3 falls back to add and is flagged
    always_comb begin
        alu_control_o   = AluAdd;
        funct_illegal_o = 1'b0;
        case (alu_op_i)
            AluOpSub: alu_control_o = AluSub;
            AluOpFunct: begin
                case (funct3_i)
                    3'b000: begin
                        // Only R-type distinguishes sub via funct7b5; addi has no such bit
                        if (op_i == OpRtype && funct7b5_i) begin
                            alu_control_o = AluSub;
                        end
                    end
                    3'b010:  alu_control_o = AluSlt;
                    3'b110:  alu_control_o = AluOr;
                    3'b111:  alu_control_o = AluAnd;
                    default: funct_illegal_o = 1'b1;
                endcase
            end
            default: alu_control_o = AluAdd;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: sequences a shared ALU and unified memory port.
module multicycle_controller
    import multicycle_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       mem_req_o,
    output logic       adr_src_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic       reg_write_o,
    output logic       mem_write_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] result_src_o,
    output logic [2:0] alu_control_o,
    output logic [1:0] imm_src_o,
    output logic       illegal_instr_o
);

    state_e     state_q, state_d;
    logic [1:0] alu_op;
    logic       decode_illegal;
    logic       funct_illegal;
    logic       op_supported;

    assign op_supported = (op_i == OpLoad)  || (op_i == OpStore) || (op_i == OpRtype) ||
                          (op_i == OpItype) || (op_i == OpBeq)   || (op_i == OpJal);

    // State register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; memory states hold until mem_ready
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:    if (mem_ready_i) state_d = StDecode;
            StDecode: begin
                case (op_i)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRtype:         state_d = StExecuteR;
                    OpItype:         state_d = StExecuteI;
                    OpBeq:           state_d = StBeq;
                    OpJal:           state_d = StJal;
                    default:         state_d = StFetch;
                endcase
            end
            StMemAdr:   state_d = (op_i == OpLoad) ? StMemRead : StMemWrite;
            StMemRead:  if (mem_ready_i) state_d = StMemWb;
            StMemWrite: if (mem_ready_i) state_d = StFetch;
            StMemWb:    state_d = StFetch;
            StExecuteR: state_d = StAluWb;
            StExecuteI: state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StBeq:      state_d = StFetch;
            StJal:      state_d = StAluWb;
            default:    state_d = StFetch;
        endcase
    end

    // Output decode; enables are forced low while reset is asserted
    always_comb begin
        mem_req_o      = 1'b0;
        adr_src_o      = 1'b0;
        ir_write_o     = 1'b0;
        pc_write_o     = 1'b0;
        reg_write_o    = 1'b0;
        mem_write_o    = 1'b0;
        alu_src_a_o    = SrcAPc;
        alu_src_b_o    = SrcBRegB;
        result_src_o   = ResAluOut;
        alu_op         = AluOpAdd;
        decode_illegal = 1'b0;
        unique case (state_q)
            StFetch: begin
                mem_req_o    = 1'b1;
                alu_src_b_o  = SrcBFour;
                result_src_o = ResAluResult;
                ir_write_o   = mem_ready_i;
                pc_write_o   = mem_ready_i;
            end
            StDecode: begin
                alu_src_a_o    = SrcAOldPc;
                alu_src_b_o    = SrcBImm;
                decode_illegal = !op_supported;
            end
            StMemAdr: begin
                alu_src_a_o = SrcARegA;
                alu_src_b_o = SrcBImm;
            end
            StMemRead: begin
                mem_req_o = 1'b1;
                adr_src_o = 1'b1;
            end
            StMemWrite: begin
                mem_req_o   = 1'b1;
                adr_src_o   = 1'b1;
                mem_write_o = 1'b1;
            end
            StMemWb: begin
                result_src_o = ResMemData;
                reg_write_o  = 1'b1;
            end
            StExecuteR: begin
                alu_src_a_o = SrcARegA;
                alu_src_b_o = SrcBRegB;
                alu_op      = AluOpFunct;
            end
            StExecuteI: begin
                alu_src_a_o = SrcARegA;
                alu_src_b_o = SrcBImm;
                alu_op      = AluOpFunct;
            end
            StAluWb: begin
                result_src_o = ResAluOut;
                reg_write_o  = 1'b1;
            end
            StBeq: begin
                alu_src_a_o = SrcARegA;
                alu_src_b_o = SrcBRegB;
                alu_op      = AluOpSub;
                pc_write_o  = zero_i;
            end
            StJal: begin
                alu_src_a_o = SrcAOldPc;
                alu_src_b_o = SrcBFour;
                pc_write_o  = 1'b1;
            end
            default: ;
        endcase
        if (reset_i) begin
            mem_req_o      = 1'b0;
            ir_write_o     = 1'b0;
            pc_write_o     = 1'b0;
            reg_write_o    = 1'b0;
            mem_write_o    = 1'b0;
            decode_illegal = 1'b0;
        end
    end

    alu_decoder u_alu_decoder (
        .op_i            (op_i),
        .funct3_i        (funct3_i),
        .funct7b5_i      (funct7b5_i),
        .alu_op_i        (alu_op),
        .alu_control_o   (alu_control_o),
        .funct_illegal_o (funct_illegal)
    );

    assign imm_src_o       = imm_src_for(op_i);
    assign illegal_instr_o = !reset_i && (decode_illegal || funct_illegal);

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle vector table plus a stall sequence.
module tb_multicycle_controller;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1110011;

    typedef enum {TFetch, TDecode, TMemAdr, TMemRead, TMemWb, TMemWrite,
                  TExecR, TExecI, TAluWb, TBeq, TJal} tst_e;

    typedef struct packed {
        logic       mem_req;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       mem_write;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] rs;
        logic [2:0] alu;
        logic [1:0] imm;
        logic       ill;
    } out_t;

    typedef struct {
        logic       rst;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        logic       mr;
        tst_e       st;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset, funct7b5, zero, mem_ready;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       mem_req, adr_src, ir_write, pc_write, reg_write, mem_write, illegal_instr;
    logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
    logic [2:0] alu_control;
    out_t       got;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[$];
    out_t sb[$];

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .op_i            (op),
        .funct3_i        (funct3),
        .funct7b5_i      (funct7b5),
        .zero_i          (zero),
        .mem_ready_i     (mem_ready),
        .mem_req_o       (mem_req),
        .adr_src_o       (adr_src),
        .ir_write_o      (ir_write),
        .pc_write_o      (pc_write),
        .reg_write_o     (reg_write),
        .mem_write_o     (mem_write),
        .alu_src_a_o     (alu_src_a),
        .alu_src_b_o     (alu_src_b),
        .result_src_o    (result_src),
        .alu_control_o   (alu_control),
        .imm_src_o       (imm_src),
        .illegal_instr_o (illegal_instr)
    );

    assign got = {mem_req, adr_src, ir_write, pc_write, reg_write, mem_write,
                  alu_src_a, alu_src_b, result_src, alu_control, imm_src, illegal_instr};

    // Expected outputs for a given state and inputs, written from the control table
    function automatic out_t exp_out(tst_e s, logic [6:0] o, logic [2:0] f3, logic f7,
                                     logic z, logic mr, logic rst);
        out_t e;
        e = '0;
        if (o == SW)      e.imm = 2'b01;
        else if (o == BQ) e.imm = 2'b10;
        else if (o == JL) e.imm = 2'b11;
        case (s)
            TFetch:    begin e.mem_req = 1; e.b = 2'b10; e.rs = 2'b10;
                             e.ir_write = mr; e.pc_write = mr; end
            TDecode:   begin e.a = 2'b01; e.b = 2'b01;
                             e.ill = !(o inside {LW, SW, RT, IT, BQ, JL}); end
            TMemAdr:   begin e.a = 2'b10; e.b = 2'b01; end
            TMemRead:  begin e.mem_req = 1; e.adr_src = 1; end
            TMemWrite: begin e.mem_req = 1; e.adr_src = 1; e.mem_write = 1; end
            TMemWb:    begin e.rs = 2'b01; e.reg_write = 1; end
            TExecR, TExecI: begin
                e.a = 2'b10;
                e.b = (s == TExecI) ? 2'b01 : 2'b00;
                case (f3)
                    3'b000:  e.alu = (o == RT && f7) ? 3'b001 : 3'b000;
                    3'b010:  e.alu = 3'b101;
                    3'b110:  e.alu = 3'b011;
                    3'b111:  e.alu = 3'b010;
                    default: e.ill = 1;
                endcase
            end
            TAluWb:    e.reg_write = 1;
            TBeq:      begin e.a = 2'b10; e.alu = 3'b001; e.pc_write = z; end
            TJal:      begin e.a = 2'b01; e.b = 2'b10; e.pc_write = 1; end
            default:   ;
        endcase
        if (rst) begin
            e.mem_req = 0; e.ir_write = 0; e.pc_write = 0;
            e.reg_write = 0; e.mem_write = 0; e.ill = 0;
        end
        return e;
    endfunction

    task automatic add(logic r, logic [6:0] o, logic [2:0] f3, logic f7, logic z, logic mr,
                       tst_e st);
        vec_t v;
        v.rst = r; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.mr = mr; v.st = st;
        vecs.push_back(v);
    endtask

    task automatic check(string name, logic ok, logic [31:0] act, logic [31:0] req);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    initial begin
        int   n, cnt;
        logic saw_rw;
        out_t exp;

        reset = 1; op = LW; funct3 = 3'b010; funct7b5 = 0; zero = 0; mem_ready = 0;
        repeat (2) @(negedge clk);

        // Reset row: state known FETCH, enables gated even with mem_ready high
        add(1, LW, 3'b010, 0, 0, 1, TFetch);
        // lw, 5 cycles, mem_ready ignored in DECODE/MEMADR
        add(0, LW, 3'b010, 0, 0, 1, TFetch);
        add(0, LW, 3'b010, 0, 0, 0, TDecode);
        add(0, LW, 3'b010, 0, 0, 0, TMemAdr);
        add(0, LW, 3'b010, 0, 0, 1, TMemRead);
        add(0, LW, 3'b010, 0, 0, 0, TMemWb);
        // sw with three stall cycles in MEMWRITE
        add(0, SW, 3'b010, 0, 0, 1, TFetch);
        add(0, SW, 3'b010, 0, 0, 1, TDecode);
        add(0, SW, 3'b010, 0, 0, 1, TMemAdr);
        add(0, SW, 3'b010, 0, 0, 0, TMemWrite);
        add(0, SW, 3'b010, 0, 0, 0, TMemWrite);
        add(0, SW, 3'b010, 0, 0, 0, TMemWrite);
        add(0, SW, 3'b010, 0, 0, 1, TMemWrite);
        // Fetch stall, then R-type sub
        add(0, RT, 3'b000, 1, 0, 0, TFetch);
        add(0, RT, 3'b000, 1, 0, 0, TFetch);
        add(0, RT, 3'b000, 1, 0, 1, TFetch);
        add(0, RT, 3'b000, 1, 0, 1, TDecode);
        add(0, RT, 3'b000, 1, 0, 1, TExecR);
        add(0, RT, 3'b000, 1, 0, 1, TAluWb);
        // Same funct bits as I-type: add
        add(0, IT, 3'b000, 1, 0, 1, TFetch);
        add(0, IT, 3'b000, 1, 0, 1, TDecode);
        add(0, IT, 3'b000, 1, 0, 1, TExecI);
        add(0, IT, 3'b000, 1, 0, 1, TAluWb);
        // slt, or, and
        add(0, RT, 3'b010, 0, 0, 1, TFetch);
        add(0, RT, 3'b010, 0, 0, 1, TDecode);
        add(0, RT, 3'b010, 0, 0, 1, TExecR);
        add(0, RT, 3'b010, 0, 0, 1, TAluWb);
        add(0, IT, 3'b110, 0, 0, 1, TFetch);
        add(0, IT, 3'b110, 0, 0, 1, TDecode);
        add(0, IT, 3'b110, 0, 0, 1, TExecI);
        add(0, IT, 3'b110, 0, 0, 1, TAluWb);
        add(0, RT, 3'b111, 1, 0, 1, TFetch);
        add(0, RT, 3'b111, 1, 0, 1, TDecode);
        add(0, RT, 3'b111, 1, 0, 1, TExecR);
        add(0, RT, 3'b111, 1, 0, 1, TAluWb);
        // Unsupported funct3: add, illegal pulse, write still happens
        add(0, RT, 3'b001, 0, 0, 1, TFetch);
        add(0, RT, 3'b001, 0, 0, 1, TDecode);
        add(0, RT, 3'b001, 0, 0, 1, TExecR);
        add(0, RT, 3'b001, 0, 0, 1, TAluWb);
        // beq taken, then not taken (zero ignored outside BEQ)
        add(0, BQ, 3'b000, 0, 0, 1, TFetch);
        add(0, BQ, 3'b000, 0, 0, 1, TDecode);
        add(0, BQ, 3'b000, 0, 1, 1, TBeq);
        add(0, BQ, 3'b000, 0, 1, 1, TFetch);
        add(0, BQ, 3'b000, 0, 1, 1, TDecode);
        add(0, BQ, 3'b000, 0, 0, 1, TBeq);
        // jal
        add(0, JL, 3'b000, 0, 0, 1, TFetch);
        add(0, JL, 3'b000, 0, 0, 1, TDecode);
        add(0, JL, 3'b000, 0, 0, 1, TJal);
        add(0, JL, 3'b000, 0, 0, 1, TAluWb);
        // Unsupported opcode
        add(0, BAD, 3'b000, 0, 0, 1, TFetch);
        add(0, BAD, 3'b000, 0, 0, 1, TDecode);
        // lw abandoned by reset during MEMREAD wait
        add(0, LW, 3'b010, 0, 0, 1, TFetch);
        add(0, LW, 3'b010, 0, 0, 1, TDecode);
        add(0, LW, 3'b010, 0, 0, 1, TMemAdr);
        add(0, LW, 3'b010, 0, 0, 0, TMemRead);
        add(1, LW, 3'b010, 0, 0, 1, TMemRead);
        add(0, LW, 3'b010, 0, 0, 0, TFetch);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst; op = vecs[i].op; funct3 = vecs[i].f3;
            funct7b5 = vecs[i].f7; zero = vecs[i].z; mem_ready = vecs[i].mr;
            sb.push_back(exp_out(vecs[i].st, vecs[i].op, vecs[i].f3, vecs[i].f7,
                                 vecs[i].z, vecs[i].mr, vecs[i].rst));
            #1;
            exp = sb.pop_front();
            check($sformatf("vec%0d_%s", i, vecs[i].st.name()), got == exp,
                  32'(got), 32'(exp));
            check($sformatf("vec%0d_rw_mw_excl", i), !(reg_write && mem_write),
                  {30'd0, reg_write, mem_write}, 32'd0);
        end

        // sw with random stall length: mem_write held exactly stalls+1 cycles
        n = $urandom_range(1, 4);
        cnt = 0;
        saw_rw = 0;
        @(negedge clk); op = SW; funct3 = 3'b010; mem_ready = 1;   // FETCH
        @(negedge clk);                                            // DECODE
        @(negedge clk);                                            // MEMADR
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            mem_ready = (c == n);
            #1;
            if (mem_write) cnt++;
            if (reg_write) saw_rw = 1;
            if (c == n) break;
        end
        check("sw_stall_mem_write_cycles", cnt == n + 1, 32'(cnt), 32'(n + 1));
        @(negedge clk);
        mem_ready = 0;
        #1;
        if (reg_write) saw_rw = 1;
        check("sw_stall_back_to_fetch", mem_req && !adr_src && !mem_write && result_src == 2'b10,
              {28'd0, mem_req, adr_src, mem_write, 1'b0}, 32'h8);
        check("sw_stall_no_reg_write", !saw_rw, {31'd0, saw_rw}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
